// File: rtl/sync_pkg.sv
// Shared constants for the sync_filter block: filter modes and legal parameter ranges.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sync_pkg;

  // Filter modes
  localparam int SYNC_MODE_PASS     = 0;
  localparam int SYNC_MODE_DEBOUNCE = 1;

  // Legal parameter ranges
  localparam int SYNC_CH_MIN   = 1;
  localparam int SYNC_CH_MAX   = 32;
  localparam int SYNC_DFF_MIN  = 2;
  localparam int SYNC_DFF_MAX  = 4;
  localparam int SYNC_FILT_MIN = 1;
  localparam int SYNC_FILT_MAX = 1024;

  // True when the whole parameter set is inside the supported ranges.
  function automatic bit sync_params_ok(input int ch, input int dff, input int filt,
                                        input int mode);
    return (ch >= SYNC_CH_MIN) && (ch <= SYNC_CH_MAX) &&
           (dff >= SYNC_DFF_MIN) && (dff <= SYNC_DFF_MAX) &&
           (filt >= SYNC_FILT_MIN) && (filt <= SYNC_FILT_MAX) &&
           ((mode == SYNC_MODE_PASS) || (mode == SYNC_MODE_DEBOUNCE));
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: DFF-stage synchronizer, optional debounce filter, rise/fall pulse detect.
// Latency: DFF edges (pass) or DFF+FILT edges (debounce) from din change to dout change.
// Backpressure: none; free-running level path, pulses are single-cycle and unacknowledged.
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   DFF  = 2,
  parameter int   FILT = 4,
  parameter int   MODE = 1,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [DFF-1:0] sync_q;
  logic [DFF-1:0] sync_d;
  logic           s;
  logic           dout_prev_q;

  // New sample enters stage 0, older samples move one stage towards the output.
  assign sync_d = {sync_q[DFF-2:0], din};
  assign s      = sync_q[DFF-1];

  // Synchronizer chain; every stage comes out of reset at the channel's INIT level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {DFF{INIT}};
    else     sync_q <= sync_d;
  end

  if (MODE == SYNC_MODE_DEBOUNCE) begin : g_debounce
    localparam int             CW       = $clog2(FILT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          lvl_q;
    logic          lvl_d;

    // Count consecutive mismatch cycles; accept the new level on the FILT-th one.
    // Any matching cycle clears the count, so the counter can never pass FILT-1.
    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (s != lvl_q) begin
        if (cnt_q == CNT_LAST) begin
          lvl_d = s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    // Filter state; reset drops any partially counted transition.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        lvl_q <= INIT;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign dout = lvl_q;
  end else begin : g_pass
    assign dout = s;
  end

  // Delayed copy of dout for edge detection; shares the INIT reset level so
  // the first cycle out of reset cannot produce a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_prev_q <= INIT;
    else     dout_prev_q <= dout;
  end

  assign rise = dout & ~dout_prev_q;
  assign fall = ~dout & dout_prev_q;

endmodule

// File: rtl/sync_filter.sv
// Multi-channel asynchronous input synchronizer with optional per-channel debounce.
// Latency: DFF edges (MODE pass) or DFF+FILT edges (MODE debounce), per channel.
// Backpressure: none; outputs are levels and single-cycle rise/fall pulses.
module sync_filter
  import sync_pkg::*;
#(
  parameter int            CH   = 1,
  parameter int            DFF  = 2,
  parameter int            FILT = 4,
  parameter int            MODE = 1,
  parameter logic [CH-1:0] INIT = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] dout,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  // Reject unsupported configurations while elaborating rather than in silicon.
  if (!sync_params_ok(CH, DFF, FILT, MODE)) begin : g_bad_params
    $error("sync_filter: illegal parameters CH=%0d DFF=%0d FILT=%0d MODE=%0d",
           CH, DFF, FILT, MODE);
  end

  // Channels are fully independent copies; nothing crosses between them.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    sync_filter_ch #(
      .DFF  (DFF),
      .FILT (FILT),
      .MODE (MODE),
      .INIT (INIT[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .din  (din[i]),
      .dout (dout[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule

// File: tb/tb_sync_filter.sv
// Self-checking bench for sync_filter: four configurations share clk/rst,
// directed scenarios plus random stimulus compared every cycle to a delay-line/history model.
module tb_sync_filter;
  import sync_pkg::*;

  localparam int NI = 4;
  localparam int       CH_P   [NI] = '{2, 2, 2, 3};
  localparam int       DFF_P  [NI] = '{2, 3, 2, 4};
  localparam int       FILT_P [NI] = '{4, 4, 1, 7};
  localparam int       MODE_P [NI] = '{1, 0, 1, 1};
  localparam logic [2:0] INIT_P [NI] = '{3'b010, 3'b000, 3'b001, 3'b000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0][2:0] din_v = '0;
  logic [NI-1:0][2:0] dout_v, rise_v, fall_v;

  logic [1:0] dout0, rise0, fall0;
  logic [1:0] dout1, rise1, fall1;
  logic [1:0] dout2, rise2, fall2;
  logic [2:0] dout3, rise3, fall3;

  sync_filter #(.CH(2), .DFF(2), .FILT(4), .MODE(SYNC_MODE_DEBOUNCE), .INIT(2'b10)) u_deb (
    .clk(clk), .rst(rst), .din(din_v[0][1:0]), .dout(dout0), .rise(rise0), .fall(fall0));
  sync_filter #(.CH(2), .DFF(3), .FILT(4), .MODE(SYNC_MODE_PASS), .INIT(2'b00)) u_pass (
    .clk(clk), .rst(rst), .din(din_v[1][1:0]), .dout(dout1), .rise(rise1), .fall(fall1));
  sync_filter #(.CH(2), .DFF(2), .FILT(1), .MODE(SYNC_MODE_DEBOUNCE), .INIT(2'b01)) u_f1 (
    .clk(clk), .rst(rst), .din(din_v[2][1:0]), .dout(dout2), .rise(rise2), .fall(fall2));
  sync_filter #(.CH(3), .DFF(4), .FILT(7), .MODE(SYNC_MODE_DEBOUNCE), .INIT(3'b000)) u_wide (
    .clk(clk), .rst(rst), .din(din_v[3]), .dout(dout3), .rise(rise3), .fall(fall3));

  assign dout_v[0] = {1'b0, dout0};
  assign rise_v[0] = {1'b0, rise0};
  assign fall_v[0] = {1'b0, fall0};
  assign dout_v[1] = {1'b0, dout1};
  assign rise_v[1] = {1'b0, rise1};
  assign fall_v[1] = {1'b0, fall1};
  assign dout_v[2] = {1'b0, dout2};
  assign rise_v[2] = {1'b0, rise2};
  assign fall_v[2] = {1'b0, fall2};
  assign dout_v[3] = dout3;
  assign rise_v[3] = rise3;
  assign fall_v[3] = fall3;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: a DFF-long delay line of din samples, then a history
  // of the last FILT synchronized samples; the level flips once all of them disagree.
  bit sq    [NI][3][$];
  bit sh    [NI][3][$];
  bit mdout [NI][3];
  bit mrise [NI][3];
  bit mfall [NI][3];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      logic [2:0] iv;
      iv = INIT_P[i];
      for (int c = 0; c < CH_P[i]; c++) begin
        sq[i][c].delete();
        sh[i][c].delete();
        for (int k = 0; k < DFF_P[i]; k++) sq[i][c].push_back(iv[c]);
        mdout[i][c] = iv[c];
        mrise[i][c] = 1'b0;
        mfall[i][c] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < CH_P[i]; c++) begin
        bit pre_s, prev, all_diff;
        pre_s = sq[i][c][0];
        prev  = mdout[i][c];
        if (MODE_P[i] == SYNC_MODE_DEBOUNCE) begin
          sh[i][c].push_back(pre_s);
          if (sh[i][c].size() > FILT_P[i]) void'(sh[i][c].pop_front());
          if (sh[i][c].size() == FILT_P[i]) begin
            all_diff = 1'b1;
            for (int k = 0; k < sh[i][c].size(); k++)
              if (sh[i][c][k] == prev) all_diff = 1'b0;
            if (all_diff) mdout[i][c] = pre_s;
          end
        end
        sq[i][c].push_back(din_v[i][c]);
        void'(sq[i][c].pop_front());
        if (MODE_P[i] == SYNC_MODE_PASS) mdout[i][c] = sq[i][c][0];
        mrise[i][c] = mdout[i][c] & !prev;
        mfall[i][c] = !mdout[i][c] & prev;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      logic [2:0] ed, er, ef;
      ed = '0; er = '0; ef = '0;
      for (int c = 0; c < CH_P[i]; c++) begin
        ed[c] = mdout[i][c];
        er[c] = mrise[i][c];
        ef[c] = mfall[i][c];
      end
      check($sformatf("dout[%0d]", i), dout_v[i], ed);
      check($sformatf("rise[%0d]", i), rise_v[i], er);
      check($sformatf("fall[%0d]", i), fall_v[i], ef);
    end
  endtask

  // One clock edge: advance the model with the pre-edge inputs, then compare 1ns later.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_all();
  endtask

  int lat0, lat1, lat2, lat3, nrise0, nrise1, seen, rst_cnt;

  initial begin
    din_v[0] = 3'b010;
    din_v[2] = 3'b001;
    model_reset();
    repeat (3) step();
    check("reset_dout0", dout_v[0], 3'b010);
    check("reset_pulse0", {rise_v[0], fall_v[0]}, 6'b0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rise_v[0] != 0 || fall_v[0] != 0 || dout_v[0] != 3'b010) seen++;
    end
    check("post_reset_quiet", seen, 0);

    // Glitch of 3 cycles on a 4-cycle filter must be swallowed.
    din_v[0][0] = 1'b1;
    repeat (3) step();
    din_v[0][0] = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rise_v[0][0] || dout_v[0][0]) seen++;
    end
    check("glitch_reject", seen, 0);

    // Latency: debounce DFF2/FILT4, pass DFF3, debounce FILT1.
    din_v[0][0] = 1'b1;
    din_v[1][0] = 1'b1;
    din_v[2][1] = 1'b1;
    lat0 = 0; lat1 = 0; lat2 = 0; nrise0 = 0; nrise1 = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (lat0 == 0 && dout_v[0][0]) lat0 = k;
      if (lat1 == 0 && dout_v[1][0]) lat1 = k;
      if (lat2 == 0 && dout_v[2][1]) lat2 = k;
      if (rise_v[0][0]) nrise0++;
      if (rise_v[1][0]) nrise1++;
    end
    check("deb_latency", lat0, 6);
    check("deb_rise_cnt", nrise0, 1);
    check("pass_latency", lat1, 3);
    check("pass_rise_cnt", nrise1, 1);
    check("filt1_latency", lat2, 3);

    // Independence: ch0 toggles every cycle, ch1 steps high.
    din_v[3][1] = 1'b1;
    lat3 = 0; seen = 0;
    for (int k = 1; k <= 20; k++) begin
      din_v[3][0] = ~din_v[3][0];
      step();
      if (lat3 == 0 && dout_v[3][1]) lat3 = k;
      if (dout_v[3][0]) seen++;
    end
    din_v[3][0] = 1'b0;
    check("indep_latency", lat3, 11);
    check("indep_toggle_hold", seen, 0);

    // Reset two cycles into a 4-cycle filter drops the pending transition.
    din_v[0] = 3'b010;
    repeat (10) step();
    check("settle_dout0", dout_v[0], 3'b010);
    din_v[0][0] = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    check("midrst_dout0", dout_v[0], 3'b010);
    repeat (2) step();
    rst = 1'b0;
    lat0 = 0; nrise0 = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) check("midrst_first_pulse", {rise_v[0], fall_v[0]}, 6'b0);
      if (lat0 == 0 && dout_v[0][0]) lat0 = k;
      if (rise_v[0][0]) nrise0++;
    end
    check("midrst_restart_lat", lat0, 6);
    check("midrst_rise_cnt", nrise0, 1);

    // Random: sparse toggles so some changes survive the filters, occasional resets.
    rst_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NI; i++)
        for (int c = 0; c < CH_P[i]; c++)
          if ($urandom_range(0, 5) == 0) din_v[i][c] = ~din_v[i][c];
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rst = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        model_reset();
        rst_cnt = 2;
      end
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
